// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring integer divider.
//
// One quotient bit is produced per clock. Operands are captured when start
// is accepted in IDLE; signed or unsigned operation is selected per
// transaction by signed_mode. Results and status flags are registered and
// held until the next completion.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (priority over start)
//   start        division request, sampled only in IDLE
//   signed_mode  operands are two's complement when 1 (captured with start)
//   dividend     numerator (captured with start)
//   divisor      denominator (captured with start)
//   quotient     registered quotient, held until next completion
//   remainder    registered remainder, held until next completion
//   ready        one-cycle pulse when new results become visible
//   busy         high from the cycle after accept until ready
//   div_by_zero  last completed operation divided by zero
//   overflow     last completed operation was signed MIN / -1
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   prem;    // partial remainder
  logic [WIDTH-1:0] qsh;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dmag;    // divisor magnitude
  logic [CW-1:0]    cnt;     // iterations remaining
  logic             neg_q;
  logic             neg_r;
  logic             dbz;
  logic             ovf;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             keep;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which fits unsigned.
  always_comb begin
    dvd_neg = signed_mode & dividend[WIDTH-1];
    dvs_neg = signed_mode & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (~dividend) + WIDTH'(1) : dividend;
    dvs_mag = dvs_neg ? (~divisor) + WIDTH'(1) : divisor;
  end

  // One restoring step: shift in the next dividend bit, then trial-subtract.
  always_comb begin
    shifted = {prem, qsh[WIDTH-1]};
    keep    = (shifted >= {2'b00, dmag});
    trial   = shifted[WIDTH:0] - {1'b0, dmag};
  end

  // Sign correction applied to the unsigned quotient/remainder.
  always_comb begin
    q_fix = neg_q ? (~qsh) + WIDTH'(1) : qsh;
    r_fix = neg_r ? (~prem[WIDTH-1:0]) + WIDTH'(1) : prem[WIDTH-1:0];
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      quotient    <= '0;
      remainder   <= '0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      prem        <= '0;
      qsh         <= '0;
      dmag        <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            neg_q <= dvd_neg ^ dvs_neg;
            neg_r <= dvd_neg;
            prem  <= '0;
            dmag  <= dvs_mag;
            cnt   <= CW'(WIDTH);
            ovf   <= signed_mode && (dividend == MIN_NEG) && (divisor == '1);
            if (divisor == '0) begin
              // Skip iterations; keep the raw dividend for the remainder.
              dbz   <= 1'b1;
              qsh   <= dividend;
              state <= FIX;
            end else begin
              dbz   <= 1'b0;
              qsh   <= dvd_mag;
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem <= keep ? trial : shifted[WIDTH:0];
          qsh  <= {qsh[WIDTH-2:0], keep};
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (dbz) begin
            quotient  <= '1;
            remainder <= qsh;
          end else if (ovf) begin
            quotient  <= MIN_NEG;
            remainder <= '0;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
          div_by_zero <= dbz;
          overflow    <= ovf;
          ready       <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: drivers push expected results computed
// with plain integer arithmetic; monitors pop and compare on every ready.
// Two instances are exercised: WIDTH=8 and WIDTH=16.
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    bit          dbz;
    bit          ovf;
    int          lat;
    longint      acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start8, sm8, rdy8, busy8, dbz8, ovf8;
  logic [7:0]  a8, b8, quo8, rem8;
  logic        start16, sm16, rdy16, busy16, dbz16, ovf16;
  logic [15:0] a16, b16, quo16, rem16;

  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;
  int     bcnt8 = 0;
  int     bcnt16 = 0;
  exp_t   q8[$];
  exp_t   q16[$];
  exp_t   e8, e16;

  seq_divider #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .dividend(a8), .divisor(b8), .quotient(quo8), .remainder(rem8),
    .ready(rdy8), .busy(busy8), .div_by_zero(dbz8), .overflow(ovf8)
  );

  seq_divider #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .dividend(a16), .divisor(b16), .quotient(quo16), .remainder(rem16),
    .ready(rdy16), .busy(busy16), .div_by_zero(dbz16), .overflow(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void timeout(string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endfunction

  // Reference: integer division with the documented special cases.
  function automatic exp_t model(int w, bit sm, longint a, longint b);
    exp_t   e;
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint sa, sb;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = w + 1;
    e.acc = 0;
    if (b == 0) begin
      e.q   = 32'(m);
      e.r   = 32'(a);
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      sa = (sm && a >= half) ? a - (m + 1) : a;
      sb = (sm && b >= half) ? b - (m + 1) : b;
      if (sm && sa == -half && sb == -1) begin
        e.q   = 32'(half);
        e.r   = 32'(0);
        e.ovf = 1'b1;
      end else begin
        e.q = 32'((sa / sb) & m);
        e.r = 32'((sa % sb) & m);
      end
    end
    return e;
  endfunction

  task automatic rand_op(input int w, output bit sm, output longint a, output longint b);
    longint m    = (longint'(1) << w) - 1;
    int     pick = $urandom_range(0, 9);
    sm = 1'($urandom_range(0, 1));
    a  = longint'($urandom) & m;
    b  = longint'($urandom) & m;
    case (pick)
      0: b = 0;
      1: begin sm = 1'b1; a = longint'(1) << (w - 1); b = m; end
      2: b = 1;
      3: b = m;
      default: ;
    endcase
  endtask

  // Monitors: one comparison set per ready pulse.
  always @(negedge clk) begin
    if (rst) begin
      bcnt8 = 0;
    end else begin
      if (rdy8) begin
        if (q8.size() == 0) begin
          timeout("unexpected_ready8");
        end else begin
          e8 = q8.pop_front();
          check("quotient8",  longint'(quo8), longint'(e8.q));
          check("remainder8", longint'(rem8), longint'(e8.r));
          check("dbz8",       longint'(dbz8), longint'(e8.dbz));
          check("ovf8",       longint'(ovf8), longint'(e8.ovf));
          check("busy_at_ready8", longint'(busy8), 0);
          check("latency8",   cyc - e8.acc, longint'(e8.lat));
          check("busy_cycles8", longint'(bcnt8), longint'(e8.lat));
        end
        bcnt8 = 0;
      end else if (busy8) begin
        bcnt8++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      bcnt16 = 0;
    end else begin
      if (rdy16) begin
        if (q16.size() == 0) begin
          timeout("unexpected_ready16");
        end else begin
          e16 = q16.pop_front();
          check("quotient16",  longint'(quo16), longint'(e16.q));
          check("remainder16", longint'(rem16), longint'(e16.r));
          check("dbz16",       longint'(dbz16), longint'(e16.dbz));
          check("ovf16",       longint'(ovf16), longint'(e16.ovf));
          check("latency16",   cyc - e16.acc, longint'(e16.lat));
          check("busy_cycles16", longint'(bcnt16), longint'(e16.lat));
        end
        bcnt16 = 0;
      end else if (busy16) begin
        bcnt16++;
      end
    end
  end

  task automatic wait_idle8(output bit ok);
    int n = 0;
    @(negedge clk);
    while (busy8 && n < 100) begin @(negedge clk); n++; end
    ok = !busy8;
    if (!ok) timeout("idle8");
  endtask

  task automatic issue8(input bit sm, input longint a, input longint b);
    exp_t e;
    bit   ok;
    wait_idle8(ok);
    if (!ok) return;
    start8 = 1'b1; sm8 = sm; a8 = 8'(a); b8 = 8'(b);
    @(posedge clk); #1;
    e = model(8, sm, a, b);
    e.acc = cyc;
    q8.push_back(e);
    start8 = 1'b0; sm8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic wait_done8();
    int n = 0;
    while (q8.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (q8.size() != 0) begin timeout("done8"); q8.delete(); end
  endtask

  // start held high: a new operation is accepted on every return to IDLE.
  task automatic stream8(input int cnt);
    bit     sm, ok;
    longint a, b;
    exp_t   e;
    int     n;
    wait_idle8(ok);
    if (!ok) return;
    rand_op(8, sm, a, b);
    start8 = 1'b1; sm8 = sm; a8 = 8'(a); b8 = 8'(b);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk); #1;
      e = model(8, sm, a, b);
      e.acc = cyc;
      q8.push_back(e);
      if (i == cnt - 1) begin
        start8 = 1'b0;
      end else begin
        rand_op(8, sm, a, b);
        sm8 = sm; a8 = 8'(a); b8 = 8'(b);
        n = 0;
        @(negedge clk);
        while (!rdy8 && n < 100) begin @(negedge clk); n++; end
        if (!rdy8) begin timeout("stream_ready8"); start8 = 1'b0; return; end
      end
    end
    wait_done8();
  endtask

  task automatic issue16(input bit sm, input longint a, input longint b);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (busy16 && n < 100) begin @(negedge clk); n++; end
    if (busy16) begin timeout("idle16"); return; end
    start16 = 1'b1; sm16 = sm; a16 = 16'(a); b16 = 16'(b);
    @(posedge clk); #1;
    e = model(16, sm, a, b);
    e.acc = cyc;
    q16.push_back(e);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
  endtask

  task automatic wait_done16();
    int n = 0;
    while (q16.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (q16.size() != 0) begin timeout("done16"); q16.delete(); end
  endtask

  task automatic check_reset8(string tag);
    check({tag, "_quotient"},  longint'(quo8), 0);
    check({tag, "_remainder"}, longint'(rem8), 0);
    check({tag, "_ready"},     longint'(rdy8), 0);
    check({tag, "_busy"},      longint'(busy8), 0);
    check({tag, "_dbz"},       longint'(dbz8), 0);
    check({tag, "_ovf"},       longint'(ovf8), 0);
  endtask

  initial begin
    bit     sm;
    longint a, b;
    rst = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check_reset8("reset8");
    check("reset16_busy", longint'(busy16), 0);
    check("reset16_quotient", longint'(quo16), 0);
    rst = 1'b0;

    // Directed 8-bit cases.
    issue8(1'b0, 183, 11);   wait_done8();
    issue8(1'b1, 'hF9, 'h02); wait_done8();
    issue8(1'b0, 'hF9, 'h02); wait_done8();
    issue8(1'b0, 200, 0);    wait_done8();
    issue8(1'b0, 100, 7);    wait_done8();
    issue8(1'b1, 'h80, 'hFF); wait_done8();
    issue8(1'b1, 'h80, 'h01); wait_done8();
    issue8(1'b1, 'h07, 'hFE); wait_done8();
    issue8(1'b1, 'h80, 'h00); wait_done8();
    issue8(1'b0, 255, 255);  wait_done8();

    // Start pulse mid-CALC must be ignored.
    issue8(1'b0, 100, 9);
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'd255; b8 = 8'd1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();

    // Reset on the 4th CALC edge aborts with no ready pulse.
    issue8(1'b0, 250, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset8("abort8");
    q8.delete();
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue8(1'b1, 'hE0, 'h05); wait_done8();

    // Randomized single operations and back-to-back streams.
    for (int i = 0; i < 40; i++) begin
      rand_op(8, sm, a, b);
      issue8(sm, a, b);
      wait_done8();
    end
    stream8(30);
    stream8(10);

    // 16-bit instance.
    issue16(1'b0, 50000, 7);       wait_done16();
    issue16(1'b1, 'h8000, 'hFFFF); wait_done16();
    issue16(1'b1, 'hFFF9, 'h0002); wait_done16();
    issue16(1'b0, 1234, 0);        wait_done16();
    for (int i = 0; i < 20; i++) begin
      rand_op(16, sm, a, b);
      issue16(sm, a, b);
      wait_done16();
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle integer divider: one radix-2 restoring iteration per clock, with operand width set by parameter and signed or unsigned operation chosen per transaction. It is the next-generation replacement for the fixed 8-bit start/ready divider in the arithmetic datapath. It adds divide-by-zero and signed-overflow reporting, a busy indication, and deterministic back-to-back operation.

## Interface
- WIDTH, 8, operand and result width in bits; legal range is 4..32.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a division; sampled only in IDLE.
- signed_mode  in  1  operands are two's complement when 1; captured with start.
- dividend  in  WIDTH  numerator; captured with start.
- divisor  in  WIDTH  denominator; captured with start.
- quotient  out  WIDTH  registered result; held until the next completion.
- remainder  out  WIDTH  registered result; held until the next completion.
- ready  out  1  one-cycle pulse; results are valid from this cycle onward.
- busy  out  1  high from the cycle after start is accepted until ready.
- div_by_zero  out  1  status of the last completed operation; held.
- overflow  out  1  status of the last completed operation; held.

## Operation
- States:
  - IDLE: accepts start.
  - CALC: WIDTH iterations.
  - FIX: sign correction and result register write.
- IDLE with start=1:
  - Capture the operands and signed_mode.
  - Form the magnitudes: absolute value if signed_mode and the MSB is set, otherwise the raw value. A magnitude is WIDTH bits, unsigned; the magnitude of the most negative value fits.
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend). Both are 0 when unsigned.
  - Clear the WIDTH+1-bit partial remainder, load the iteration counter with WIDTH, and go to CALC.
  - If divisor == 0, go directly to FIX with the dbz flag set.
- CALC iteration, one per cycle:
  - Shift the {partial remainder, dividend-magnitude} pair left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder. If the result is non-negative, keep it and shift in 1; otherwise restore and shift in 0.
  - Decrement the counter. When the counter reaches 0, go to FIX.
- FIX:
  - quotient = neg_q ? -q : q (mod 2^WIDTH).
  - remainder = neg_r ? -r : r.
  - Pulse ready for one cycle, update the status flags, and return to IDLE.
- Divide by zero:
  - quotient = all ones, remainder = dividend (raw), div_by_zero = 1, overflow = 0.
- Signed overflow: signed_mode with dividend = -2^(WIDTH-1) and divisor = -1.
  - quotient = -2^(WIDTH-1) (wrapped), remainder = 0, overflow = 1.
- Signed semantics: the quotient truncates toward zero; the remainder takes the sign of the dividend; dividend = quotient*divisor + remainder.
- start is ignored while busy; there is no queueing.
- Operand inputs are don't-care except in the start-accept cycle.

## Timing
- Reset values: quotient = 0, remainder = 0, ready = 0, busy = 0, div_by_zero = 0, overflow = 0, state = IDLE.
- rst has priority over start. rst asserted in CALC or FIX aborts the operation:
  - outputs return to their reset values at that edge;
  - no ready pulse is issued.
- Normal latency, with start accepted at edge E:
  - busy = 1 after E;
  - the CALC iterations occur at edges E+1 .. E+WIDTH;
  - FIX occurs at edge E+WIDTH+1.
  - ready = 1 and the new results are visible in the cycle after E+WIDTH+1.
  - Total: WIDTH+1 cycles from accept to results visible.
- Divide-by-zero latency: FIX at E+1, so ready is visible after E+1 (1 cycle).
- busy falls in the same cycle that ready rises.
- Throughput: start high in the ready cycle is accepted (the state is IDLE), giving one result every WIDTH+2 cycles.
- start held high continuously starts a new operation every time IDLE is reached.

## Test plan
- WIDTH=8, unsigned, dividend=183, divisor=11, single start -> after 9 cycles, ready pulses once; quotient=16, remainder=7; both flags 0; busy high for exactly 9 cycles.
- WIDTH=8, signed, dividend=8'hF9 (-7), divisor=8'h02 -> quotient=8'hFD (-3), remainder=8'hFF (-1). Same operands with signed_mode=0 -> quotient=124, remainder=1.
- WIDTH=8, dividend=200, divisor=0 -> ready 1 cycle after accept; quotient=8'hFF, remainder=8'hC8, div_by_zero=1. The next normal operation clears the flag.
- WIDTH=8, signed, dividend=8'h80, divisor=8'hFF -> quotient=8'h80, remainder=0, overflow=1.
- WIDTH=16, unsigned, dividend=50000, divisor=7 -> ready after 17 cycles; quotient=7142, remainder=6.
- Protocol:
  - Start pulse in mid-CALC -> ignored; results correspond to the first operands.
  - Start in the ready cycle -> accepted; back-to-back results are correct.
  - rst at the 4th CALC cycle -> all outputs 0, no ready pulse; a subsequent start completes normally.
